// File: rtl/sar_scan_sequencer_if.sv
// sar_scan_sequencer_if: converter-side bus between the scan sequencer and the 5-bit SAR ADC
interface sar_scan_sequencer_if #(parameter int CH_W = 2);
  logic            nStartCnv;
  logic            nEndCnv;
  logic [4:0]      dataOut;
  logic [CH_W-1:0] muxSel;
  modport master(output nStartCnv, muxSel, input nEndCnv, dataOut);
  modport slave(input nStartCnv, muxSel, output nEndCnv, dataOut);
endinterface

// File: rtl/sar_scan_sequencer.sv
// sar_scan_sequencer: one-shot/continuous multi-channel scan controller for a 5-bit SAR ADC
module sar_scan_sequencer #(
  parameter int NUM_CH  = 4,
  parameter int CH_W    = 2,
  parameter int DIV_W   = 8,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 63
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  single,
  input  logic [NUM_CH-1:0]     chMask,
  input  logic [DIV_W-1:0]      interval,
  input  logic                  errClr,
  sar_scan_sequencer_if.master  cnv,
  output logic [NUM_CH*5-1:0]   resultBus,
  output logic [NUM_CH-1:0]     validMask,
  output logic                  scanDone,
  output logic                  busy,
  output logic                  timeoutErr
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_START, S_CONV, S_STORE, S_NEXT, S_INTERVAL} state_t;
  state_t state;
  logic [NUM_CH-1:0] scan_mask;
  logic [CH_W-1:0] mux_sel, first_ch, next_ch;
  logic [DIV_W-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic n_start, has_next;
  assign cnv.nStartCnv = n_start;
  assign cnv.muxSel = mux_sel;
  always_comb begin
    first_ch = '0;
    next_ch = '0;
    has_next = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (chMask[i]) first_ch = CH_W'(i);
      if (scan_mask[i] && i > int'(mux_sel)) begin
        has_next = 1'b1;
        next_ch = CH_W'(i);
      end
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      scan_mask <= '0;
      mux_sel <= '0;
      cnt <= '0;
      tcnt <= '0;
      n_start <= 1'b1;
      resultBus <= '0;
      validMask <= '0;
      scanDone <= 1'b0;
      busy <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      scanDone <= 1'b0;
      if (errClr) timeoutErr <= 1'b0;
      case (state)
        S_IDLE:
          if ((enable || single) && |chMask) begin
            scan_mask <= chMask;
            mux_sel <= first_ch;
            cnt <= '0;
            busy <= 1'b1;
            state <= S_SETTLE;
          end
        S_SETTLE:
          if (cnt != DIV_W'(SETTLE - 1)) cnt <= cnt + 1'b1;
          else if (!cnv.nEndCnv) begin
            n_start <= 1'b0;
            tcnt <= '0;
            state <= S_START;
          end
        S_START, S_CONV:
          // a hung converter aborts the channel; the sticky flag set here overrides errClr
          if (tcnt == TW'(TIMEOUT - 1)) begin
            n_start <= 1'b1;
            validMask[mux_sel] <= 1'b0;
            timeoutErr <= 1'b1;
            state <= S_NEXT;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (state == S_START && cnv.nEndCnv) begin
              n_start <= 1'b1;
              state <= S_CONV;
            end else if (state == S_CONV && !cnv.nEndCnv) state <= S_STORE;
          end
        S_STORE: begin
          resultBus[5*mux_sel +: 5] <= cnv.dataOut;
          validMask[mux_sel] <= 1'b1;
          state <= S_NEXT;
        end
        S_NEXT:
          if (has_next) begin
            mux_sel <= next_ch;
            cnt <= '0;
            state <= S_SETTLE;
          end else begin
            scanDone <= 1'b1;
            cnt <= '0;
            busy <= enable;
            state <= enable ? S_INTERVAL : S_IDLE;
          end
        S_INTERVAL:
          if (!enable) begin
            busy <= 1'b0;
            state <= S_IDLE;
          end else if (cnt != interval) cnt <= cnt + 1'b1;
          else if (|chMask) begin
            scan_mask <= chMask;
            mux_sel <= first_ch;
            cnt <= '0;
            state <= S_SETTLE;
          end else begin
            busy <= 1'b0;
            state <= S_IDLE;
          end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sar_scan_sequencer.sv
// tb_sar_scan_sequencer: random scans against a behavioural SAR converter model with a scan scoreboard
module tb_sar_scan_sequencer;
  localparam int NUM_CH = 4, CH_W = 2, DIV_W = 8, SETTLE = 2, TIMEOUT = 63;
  typedef struct {logic [NUM_CH*5-1:0] res; logic [NUM_CH-1:0] val;} exp_t;
  logic clock = 0, reset = 0, enable = 0, single = 0, errClr = 0;
  logic [NUM_CH-1:0] chMask = '0;
  logic [DIV_W-1:0] interval = '0;
  logic [NUM_CH*5-1:0] resultBus;
  logic [NUM_CH-1:0] validMask;
  logic scanDone, busy, timeoutErr;
  sar_scan_sequencer_if #(.CH_W(CH_W)) cnv();
  sar_scan_sequencer #(.NUM_CH(NUM_CH), .CH_W(CH_W), .DIV_W(DIV_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .enable(enable), .single(single), .chMask(chMask),
    .interval(interval), .errClr(errClr), .cnv(cnv), .resultBus(resultBus),
    .validMask(validMask), .scanDone(scanDone), .busy(busy), .timeoutErr(timeoutErr));
  always #5 clock = ~clock;
  int checks = 0, passes = 0, starts = 0, dones = 0, prev = -1, hang_ch = -1, hang_lows = 0;
  int force_data[NUM_CH];
  logic [4:0] ref_res[NUM_CH];
  logic ref_val[NUM_CH];
  exp_t exp_q[$];
  longint cyc = 0, last_done_cyc = 0;
  bit after_done = 0, check_iv = 0;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic int next_set(input logic [NUM_CH-1:0] m, input int after);
    for (int i = after + 1; i < NUM_CH; i++) if (m[i]) return i;
    return -1;
  endfunction
  function automatic int top_set(input logic [NUM_CH-1:0] m);
    for (int i = NUM_CH - 1; i >= 0; i--) if (m[i]) return i;
    return -1;
  endfunction
  task automatic finish_conv(input int c);
    exp_t e;
    prev = c;
    if (c == top_set(chMask)) begin
      for (int i = 0; i < NUM_CH; i++) begin
        e.res[5*i +: 5] = ref_res[i];
        e.val[i] = ref_val[i];
      end
      exp_q.push_back(e);
      prev = -1;
    end
  endtask
  // converter model: random start latency and conversion time, optional hang on one channel
  initial begin
    int phase, d, ch;
    phase = 0; d = 0; ch = 0;
    cnv.nEndCnv = 0;
    cnv.dataOut = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        phase = 0;
        prev = -1;
        cnv.nEndCnv = 0;
      end else case (phase)
        0: if (!cnv.nStartCnv) begin
          ch = int'(cnv.muxSel);
          starts++;
          check("mux_order", ch, next_set(chMask, prev));
          if (check_iv && after_done) check("interval_gap", cyc - last_done_cyc, interval + 1 + SETTLE);
          after_done = 0;
          if (ch == hang_ch) begin phase = 3; hang_lows = 1; end
          else begin d = $urandom_range(0, 2); phase = 1; end
        end
        1: if (d == 0) begin cnv.nEndCnv = 1; d = $urandom_range(1, 6); phase = 2; end else d--;
        2: if (d == 0) begin
          cnv.nEndCnv = 0;
          cnv.dataOut = force_data[ch] >= 0 ? 5'(force_data[ch]) : 5'($urandom);
          ref_res[ch] = cnv.dataOut;
          ref_val[ch] = 1;
          finish_conv(ch);
          phase = 0;
        end else d--;
        default: if (cnv.nStartCnv) begin
          check("timeout_len", hang_lows, TIMEOUT);
          ref_val[ch] = 0;
          finish_conv(ch);
          phase = 0;
        end else hang_lows++;
      endcase
    end
  end
  initial forever begin
    exp_t e;
    @(negedge clock);
    if (reset && scanDone) begin
      dones++;
      last_done_cyc = cyc;
      after_done = 1;
      check("scan_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("resultBus", resultBus, e.res);
        check("validMask", validMask, e.val);
      end
    end
  end
  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic wait_dones(input int n, input int budget);
    int target, k;
    target = dones + n;
    k = 0;
    while (dones < target && k < budget) begin @(negedge clock); k++; end
    check("done_in_time", dones >= target, 1);
  endtask
  task automatic wait_conv(input int c);
    int k;
    k = 0;
    while (!(cnv.nEndCnv && (c < 0 || int'(cnv.muxSel) == c)) && k < 500) begin @(negedge clock); k++; end
    check("conv_seen", cnv.nEndCnv, 1);
  endtask
  task automatic pulse_single(input logic [NUM_CH-1:0] m);
    chMask = m;
    single = 1;
    @(negedge clock);
    single = 0;
  endtask
  task automatic check_reset_vals(input string tag);
    check({tag, "_nStartCnv"}, cnv.nStartCnv, 1);
    check({tag, "_muxSel"}, cnv.muxSel, 0);
    check({tag, "_resultBus"}, resultBus, 0);
    check({tag, "_validMask"}, validMask, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_timeoutErr"}, timeoutErr, 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int s, d, bad;
    for (int i = 0; i < NUM_CH; i++) begin force_data[i] = -1; ref_res[i] = 0; ref_val[i] = 0; end
    repeat (5) begin
      @(negedge clock);
      enable = 1'($urandom); single = 1'($urandom); chMask = 4'($urandom);
      interval = 8'($urandom); errClr = 1'($urandom);
    end
    check_reset_vals("rst");
    check("rst_scanDone", scanDone, 0);
    enable = 0; single = 0; errClr = 0; chMask = 0; interval = 0;
    reset = 1;
    cycles(5);
    check_reset_vals("post_rst");
    check("post_rst_starts", starts, 0);
    force_data[0] = 9; force_data[2] = 22;
    pulse_single(4'b0101);
    wait_dones(1, 300);
    check("oneshot_ch0", resultBus[4:0], 9);
    check("oneshot_ch2", resultBus[14:10], 22);
    check("oneshot_valid", validMask, 4'b0101);
    check("oneshot_busy", busy, 0);
    check("oneshot_starts", starts, 2);
    force_data[0] = -1; force_data[2] = -1;
    repeat (6) begin
      pulse_single(4'($urandom_range(1, 15)));
      wait_dones(1, 300);
      check("rand_oneshot_busy", busy, 0);
    end
    chMask = 4'b0001; interval = 10; check_iv = 1; after_done = 0; enable = 1;
    wait_dones(3, 600);
    check("cont_busy", busy, 1);
    wait_conv(-1);
    enable = 0;
    wait_dones(1, 300);
    cycles(2);
    check("cont_stop_busy", busy, 0);
    s = starts;
    cycles(30);
    check("cont_stop_idle", starts, s);
    interval = 8'($urandom_range(0, 5)); chMask = 4'($urandom_range(1, 15)); after_done = 0; enable = 1;
    wait_dones(4, 1500);
    wait_conv(-1);
    enable = 0;
    wait_dones(1, 300);
    check_iv = 0;
    cycles(2);
    hang_ch = 0;
    pulse_single(4'b0011);
    wait_dones(1, 400);
    hang_ch = -1;
    check("to_err", timeoutErr, 1);
    check("to_valid0", validMask[0], 0);
    check("to_valid1", validMask[1], 1);
    errClr = 1;
    @(negedge clock);
    errClr = 0;
    check("errclr", timeoutErr, 0);
    chMask = 0; enable = 1; s = starts; d = dones; bad = 0;
    repeat (100) begin @(negedge clock); if (busy) bad++; end
    check("empty_busy", bad, 0);
    check("empty_starts", starts, s);
    check("empty_dones", dones, d);
    enable = 0;
    cycles(2);
    pulse_single(4'b0011);
    wait_conv(1);
    reset = 0;
    #1;
    check_reset_vals("midconv");
    exp_q.delete();
    for (int i = 0; i < NUM_CH; i++) begin ref_res[i] = 0; ref_val[i] = 0; end
    cycles(3);
    reset = 1;
    cycles(2);
    pulse_single(4'b0011);
    wait_dones(1, 300);
    check("restart_valid", validMask, 4'b0011);
    check("restart_busy", busy, 0);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
